// File: rtl/jtvigil_gfx_arb_pkg.sv
// rtl/jtvigil_gfx_arb_pkg.sv - shared types and helpers for the graphics SDRAM arbiter
package jtvigil_gfx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_DST = 2'd2
  } state_t;

  typedef logic [1:0] req_id_t;

  localparam req_id_t SCR1 = 2'd0;
  localparam req_id_t SCR2 = 2'd1;
  localparam req_id_t OBJ  = 2'd2;

  // Requester that follows id in the fixed scr1 -> scr2 -> obj -> scr1 ring
  function automatic req_id_t next_ptr(input req_id_t id);
    return (id == OBJ) ? SCR1 : req_id_t'(id + 2'd1);
  endfunction

  // First missing requester found walking the ring from ptr (ptr itself first)
  function automatic req_id_t pick_next(input req_id_t ptr, input logic [2:0] miss);
    req_id_t cand;
    req_id_t sel;
    logic    found;
    cand  = ptr;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!found && miss[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
      cand = next_ptr(cand);
    end
    return sel;
  endfunction

endpackage

// File: rtl/jtvigil_gfx_slot.sv
// rtl/jtvigil_gfx_slot.sv - one-word ROM cache slot for a single graphics fetcher
module jtvigil_gfx_slot #(
  parameter int AW_X = 17
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW_X-1:0] addr,
  input  logic            cs,
  input  logic            clear,
  input  logic            fill,
  input  logic [AW_X-1:0] fill_tag,
  input  logic [31:0]     fill_data,
  output logic [31:0]     data,
  output logic            ok,
  output logic            miss
);

  logic [AW_X-1:0] tag;
  logic            valid;

  // Tag/data/valid storage; a grant invalidates, a completed read refills
  always_ff @(posedge clk) begin
    if (rst) begin
      tag   <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else begin
      if (clear) begin
        valid <= 1'b0;
      end
      if (fill) begin
        tag   <= fill_tag;
        data  <= fill_data;
        valid <= 1'b1;
      end
    end
  end

  // ok tracks the live address so it falls in the same cycle addr moves away
  assign ok   = cs & valid & (addr == tag);
  assign miss = cs & ~ok;

endmodule

// File: rtl/jtvigil_gfx_arb.sv
// rtl/jtvigil_gfx_arb.sv - round-robin share of one SDRAM read slot among scr1, scr2 and obj
module jtvigil_gfx_arb
  import jtvigil_gfx_arb_pkg::*;
#(
  parameter int            AW        = 22,
  parameter logic [AW-1:0] SCR1_BASE = 22'h00000,
  parameter logic [AW-1:0] SCR2_BASE = 22'h20000,
  parameter logic [AW-1:0] OBJ_BASE  = 22'h60000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [16:0]   scr1_addr,
  input  logic          scr1_cs,
  output logic [31:0]   scr1_data,
  output logic          scr1_ok,
  input  logic [17:0]   scr2_addr,
  input  logic          scr2_cs,
  output logic [31:0]   scr2_data,
  output logic          scr2_ok,
  input  logic [17:0]   obj_addr,
  input  logic          obj_cs,
  output logic [31:0]   obj_data,
  output logic          obj_ok,
  output logic [AW-1:0] sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          sdram_dst,
  input  logic [31:0]   sdram_data
);

  state_t        state;
  state_t        state_nxt;
  req_id_t       ptr;
  req_id_t       gnt_id;
  logic [17:0]   gnt_addr;
  logic [2:0]    miss;
  req_id_t       pick_id;
  logic [17:0]   pick_addr;
  logic [AW-1:0] pick_word;
  logic          grant;
  logic          fill;
  logic [2:0]    clear_v;
  logic [2:0]    fill_v;

  assign pick_id = pick_next(ptr, miss);
  assign clear_v = grant ? (3'b001 << pick_id) : 3'b000;
  assign fill_v  = fill  ? (3'b001 << gnt_id)  : 3'b000;

  jtvigil_gfx_slot #(.AW_X(17)) u_scr1 (
    .clk       (clk),
    .rst       (rst),
    .addr      (scr1_addr),
    .cs        (scr1_cs),
    .clear     (clear_v[SCR1]),
    .fill      (fill_v[SCR1]),
    .fill_tag  (gnt_addr[16:0]),
    .fill_data (sdram_data),
    .data      (scr1_data),
    .ok        (scr1_ok),
    .miss      (miss[SCR1])
  );

  jtvigil_gfx_slot #(.AW_X(18)) u_scr2 (
    .clk       (clk),
    .rst       (rst),
    .addr      (scr2_addr),
    .cs        (scr2_cs),
    .clear     (clear_v[SCR2]),
    .fill      (fill_v[SCR2]),
    .fill_tag  (gnt_addr),
    .fill_data (sdram_data),
    .data      (scr2_data),
    .ok        (scr2_ok),
    .miss      (miss[SCR2])
  );

  jtvigil_gfx_slot #(.AW_X(18)) u_obj (
    .clk       (clk),
    .rst       (rst),
    .addr      (obj_addr),
    .cs        (obj_cs),
    .clear     (clear_v[OBJ]),
    .fill      (fill_v[OBJ]),
    .fill_tag  (gnt_addr),
    .fill_data (sdram_data),
    .data      (obj_data),
    .ok        (obj_ok),
    .miss      (miss[OBJ])
  );

  // Address of the requester about to be granted; the base sum wraps at AW bits
  always_comb begin
    pick_addr = '0;
    pick_word = '0;
    case (pick_id)
      SCR1: begin
        pick_addr = {1'b0, scr1_addr};
        pick_word = SCR1_BASE + AW'(scr1_addr);
      end
      SCR2: begin
        pick_addr = scr2_addr;
        pick_word = SCR2_BASE + AW'(scr2_addr);
      end
      OBJ: begin
        pick_addr = obj_addr;
        pick_word = OBJ_BASE + AW'(obj_addr);
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; ack with dst in the same cycle completes straight from WAIT_ACK
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (|miss) state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (sdram_ack) state_nxt = sdram_dst ? IDLE : WAIT_DST;
      end
      WAIT_DST: begin
        if (sdram_dst) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state strobes: grant a missing requester from IDLE, fill on the data strobe
  always_comb begin
    grant = 1'b0;
    fill  = 1'b0;
    case (state)
      IDLE:     grant = |miss;
      WAIT_ACK: fill  = sdram_ack & sdram_dst;
      WAIT_DST: fill  = sdram_dst;
      default:  ;
    endcase
  end

  // Request port, grant bookkeeping and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      gnt_id     <= SCR1;
      gnt_addr   <= '0;
      ptr        <= SCR1;
    end else begin
      if (grant) begin
        sdram_req  <= 1'b1;
        sdram_addr <= pick_word;
        gnt_id     <= pick_id;
        gnt_addr   <= pick_addr;
      end
      if (state == WAIT_ACK && sdram_ack) begin
        sdram_req <= 1'b0;
      end
      if (fill) begin
        ptr <= next_ptr(gnt_id);
      end
    end
  end

endmodule

// File: tb/tb_jtvigil_gfx_arb.sv
// tb/tb_jtvigil_gfx_arb.sv - scoreboard bench for the graphics SDRAM arbiter
module tb_jtvigil_gfx_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [16:0] scr1_addr = '0;
  logic        scr1_cs = 1'b0;
  logic [31:0] scr1_data;
  logic        scr1_ok;
  logic [17:0] scr2_addr = '0;
  logic        scr2_cs = 1'b0;
  logic [31:0] scr2_data;
  logic        scr2_ok;
  logic [17:0] obj_addr = '0;
  logic        obj_cs = 1'b0;
  logic [31:0] obj_data;
  logic        obj_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack = 1'b0;
  logic        sdram_dst = 1'b0;
  logic [31:0] sdram_data = '0;

  always #5 clk = ~clk;

  jtvigil_gfx_arb dut (
    .clk        (clk),
    .rst        (rst),
    .scr1_addr  (scr1_addr),
    .scr1_cs    (scr1_cs),
    .scr1_data  (scr1_data),
    .scr1_ok    (scr1_ok),
    .scr2_addr  (scr2_addr),
    .scr2_cs    (scr2_cs),
    .scr2_data  (scr2_data),
    .scr2_ok    (scr2_ok),
    .obj_addr   (obj_addr),
    .obj_cs     (obj_cs),
    .obj_data   (obj_data),
    .obj_ok     (obj_ok),
    .sdram_addr (sdram_addr),
    .sdram_req  (sdram_req),
    .sdram_ack  (sdram_ack),
    .sdram_dst  (sdram_dst),
    .sdram_data (sdram_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: per-requester word cache plus a single outstanding read
  logic [21:0] base [3] = '{22'h00000, 22'h20000, 22'h60000};
  logic [17:0] m_tag  [3];
  logic [31:0] m_data [3];
  bit          m_valid[3];
  int          m_ptr = 0;
  bit          m_busy = 0;
  bit          m_acked = 0;
  int          m_gid = 0;
  logic [17:0] m_gaddr = '0;
  logic [21:0] exp_q[$];
  logic [21:0] grant_log[$];

  function automatic logic [17:0] cur_addr(input int i);
    if (i == 0) return {1'b0, scr1_addr};
    if (i == 1) return scr2_addr;
    return obj_addr;
  endfunction

  function automatic bit cur_cs(input int i);
    if (i == 0) return scr1_cs;
    if (i == 1) return scr2_cs;
    return obj_cs;
  endfunction

  function automatic bit m_hit(input int i);
    return cur_cs(i) && m_valid[i] && (m_tag[i] == cur_addr(i));
  endfunction

  task automatic m_fill();
    m_tag[m_gid]   = m_gaddr;
    m_data[m_gid]  = sdram_data;
    m_valid[m_gid] = 1;
    m_ptr          = (m_gid + 1) % 3;
    m_busy         = 0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_tag[i] = '0; m_data[i] = '0; m_valid[i] = 0;
    end
  end

  always @(posedge clk) begin
    int idx;
    logic [21:0] word;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_tag[i] = '0; m_data[i] = '0; m_valid[i] = 0;
      end
      m_ptr = 0; m_busy = 0; m_acked = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < 3; k++) begin
        idx = (m_ptr + k) % 3;
        if (cur_cs(idx) && !m_hit(idx)) begin
          m_valid[idx] = 0;
          m_busy  = 1;
          m_acked = 0;
          m_gid   = idx;
          m_gaddr = cur_addr(idx);
          word    = base[idx] + {4'b0, cur_addr(idx)};
          exp_q.push_back(word);
          break;
        end
      end
    end else if (!m_acked) begin
      if (sdram_ack) begin
        m_acked = 1;
        if (sdram_dst) m_fill();
      end
    end else if (sdram_dst) begin
      m_fill();
    end
  end

  // Monitor: compare cache outputs every cycle and pop the scoreboard on each new request
  logic        prev_req = 1'b0;
  logic [21:0] cur_exp = '0;
  always @(negedge clk) begin
    check("scr1_ok", scr1_ok, m_hit(0));
    check("scr2_ok", scr2_ok, m_hit(1));
    check("obj_ok", obj_ok, m_hit(2));
    check("scr1_data", scr1_data, m_data[0]);
    check("scr2_data", scr2_data, m_data[1]);
    check("obj_data", obj_data, m_data[2]);
    check("sdram_req", sdram_req, m_busy && !m_acked);
    if (sdram_req && !prev_req) begin
      check("req_queue_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        cur_exp = exp_q.pop_front();
        grant_log.push_back(sdram_addr);
        check("req_addr", sdram_addr, cur_exp);
      end
    end else if (sdram_req) begin
      check("req_addr_stable", sdram_addr, cur_exp);
    end
    prev_req = sdram_req;
  end

  // SDRAM responder for the random phase: random ack delay, random ack-to-dst gap
  int rs = 0;
  int ack_cd = 0;
  int dst_cd = 0;
  task automatic sdram_tick();
    sdram_ack = 1'b0;
    sdram_dst = 1'b0;
    if (rst) begin
      rs = 0;
      return;
    end
    if (rs == 0 && sdram_req) begin
      rs = 1;
      ack_cd = $urandom_range(0, 2);
      dst_cd = $urandom_range(0, 3);
    end
    if (rs == 1) begin
      if (ack_cd == 0) begin
        sdram_ack = 1'b1;
        if (dst_cd == 0) begin
          sdram_dst = 1'b1; sdram_data = $urandom; rs = 0;
        end else begin
          rs = 2;
        end
      end else begin
        ack_cd--;
      end
    end else if (rs == 2) begin
      dst_cd--;
      if (dst_cd == 0) begin
        sdram_dst = 1'b1; sdram_data = $urandom; rs = 0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!sdram_req && n < 30) begin
      cyc();
      n++;
    end
    if (!sdram_req) check("req_timeout", sdram_req, 1);
  endtask

  task automatic serve(input logic [31:0] d, input bit same);
    wait_req();
    sdram_ack = 1'b1;
    if (same) begin
      sdram_dst = 1'b1; sdram_data = d;
    end
    cyc();
    sdram_ack = 1'b0;
    sdram_dst = 1'b0;
    if (!same) begin
      sdram_dst = 1'b1; sdram_data = d;
      cyc();
      sdram_dst = 1'b0;
    end
  endtask

  initial begin
    int r;
    // reset values
    rst = 1'b1;
    cyc(); cyc();
    check("rst_req", sdram_req, 0);
    check("rst_addr", sdram_addr, 0);
    check("rst_scr1_data", scr1_data, 0);
    check("rst_obj_data", obj_data, 0);
    rst = 1'b0;

    // first miss, fill and hit
    scr1_cs = 1'b1; scr1_addr = 17'h00010;
    cyc();
    check("t1_req", sdram_req, 1);
    check("t1_addr", sdram_addr, 22'h00010);
    serve(32'hDEADBEEF, 0);
    check("t1_ok", scr1_ok, 1);
    check("t1_data", scr1_data, 32'hDEADBEEF);

    // hit needs no request; address change drops ok at once
    cyc();
    check("t2_no_req", sdram_req, 0);
    check("t2_hit", scr1_ok, 1);
    scr1_addr = 17'h00011;
    #1;
    check("t2_ok_drop", scr1_ok, 0);
    cyc();
    check("t2_addr", sdram_addr, 22'h00011);
    serve($urandom, 0);

    // simultaneous misses from a fresh pointer
    rst = 1'b1;
    scr1_addr = 17'h00020; scr2_cs = 1'b1; scr2_addr = 18'h00007;
    obj_cs = 1'b1; obj_addr = 18'h00005;
    cyc();
    rst = 1'b0;
    grant_log.delete();
    serve($urandom, 0);
    serve($urandom, 0);
    serve($urandom, 0);
    check("t3_grants", grant_log.size(), 3);
    if (grant_log.size() >= 3) begin
      check("t3_first", grant_log[0], 22'h00020);
      check("t3_second", grant_log[1], 22'h20007);
      check("t3_third", grant_log[2], 22'h60005);
    end
    scr1_addr = 17'h00021; scr2_addr = 18'h00008;
    cyc();
    check("t3_ptr_scr1", sdram_addr, 22'h00021);
    serve($urandom, 0);
    serve($urandom, 0);

    // address moves while its fill is in flight
    scr1_cs = 1'b0; obj_cs = 1'b0; scr2_addr = 18'h00100;
    wait_req();
    check("t4_addr_old", sdram_addr, 22'h20100);
    sdram_ack = 1'b1;
    cyc();
    sdram_ack = 1'b0;
    scr2_addr = 18'h00200;
    sdram_dst = 1'b1; sdram_data = $urandom;
    cyc();
    sdram_dst = 1'b0;
    check("t4_ok_stays_0", scr2_ok, 0);
    wait_req();
    check("t4_addr_new", sdram_addr, 22'h20200);
    serve($urandom, 0);
    check("t4_ok_new", scr2_ok, 1);

    // reset while waiting for ack, then stray strobes in IDLE
    scr2_cs = 1'b0; scr1_cs = 1'b1; scr1_addr = 17'h00040;
    wait_req();
    rst = 1'b1; scr1_cs = 1'b0;
    cyc();
    rst = 1'b0;
    check("t5_req", sdram_req, 0);
    check("t5_addr", sdram_addr, 0);
    sdram_ack = 1'b1; sdram_dst = 1'b1; sdram_data = 32'h12345678;
    cyc();
    sdram_ack = 1'b0; sdram_dst = 1'b0;
    scr1_cs = 1'b1;
    #1;
    check("t5_no_hit", scr1_ok, 0);
    check("t5_no_write", scr1_data, 0);
    serve($urandom, 0);

    // ack and dst together
    scr1_cs = 1'b0; obj_cs = 1'b1; obj_addr = 18'h00009;
    serve(32'hCAFEF00D, 1);
    check("t6_ok", obj_ok, 1);
    check("t6_data", obj_data, 32'hCAFEF00D);
    obj_addr = 18'h0000A;
    cyc();
    check("t6_regrant", sdram_req, 1);
    check("t6_addr", sdram_addr, 22'h6000A);
    serve($urandom, 0);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      cyc();
      rst = ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, 5) == 0) begin
        r = $urandom_range(0, 2);
        if (r == 0) begin
          scr1_cs = ($urandom_range(0, 3) != 0); scr1_addr = 17'($urandom_range(0, 3));
        end else if (r == 1) begin
          scr2_cs = ($urandom_range(0, 3) != 0); scr2_addr = 18'($urandom_range(0, 3));
        end else begin
          obj_cs = ($urandom_range(0, 3) != 0); obj_addr = 18'($urandom_range(0, 3));
        end
      end
      sdram_tick();
    end

    // drain
    rst = 1'b0; scr1_cs = 1'b0; scr2_cs = 1'b0; obj_cs = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      sdram_tick();
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_req", sdram_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
